// File: rtl/seg7_pkg.sv
// Shared types and helpers for multiplexed 7-segment display controllers.
package seg7_pkg;

    typedef logic [3:0] bcd_digit_t;

    // Code the shared decoder renders as all segments off.
    localparam bcd_digit_t BLANK_CODE = 4'hF;

    localparam int MAX_DIGITS = 32;

    function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned pos);
        return MAX_DIGITS'(1) << pos;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Host-side load port and decoder-side scan outputs of the 7-segment scan controller.
interface seg7_scan_ctrl_if
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);

    logic                      load;
    logic [4*NUM_DIGITS-1:0]   bcd_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      blank_en;
    bcd_digit_t                bcd_out;
    logic [NUM_DIGITS-1:0]     digit_en;
    logic                      dp_out;
    logic                      pending;
    logic                      frame_tick;

    modport master (
        output load, bcd_in, dp_in, blank_en,
        input  bcd_out, digit_en, dp_out, pending, frame_tick
    );

    modport slave (
        input  load, bcd_in, dp_in, blank_en,
        output bcd_out, digit_en, dp_out, pending, frame_tick
    );

endinterface

// File: rtl/seg7_refresh_div.sv
// Slot timer for scanned displays: wraps every REFRESH_DIV cycles and flags the
// leading GUARD cycles of each slot during which all enables must stay off.
module seg7_refresh_div #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic wrap_o,
    output logic in_guard_o
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    cnt_t cnt_q;
    cnt_t cnt_d;

    assign wrap_o     = (cnt_q == cnt_t'(REFRESH_DIV - 1));
    assign in_guard_o = (cnt_q < cnt_t'(GUARD));

    always_comb begin
        cnt_d = wrap_o ? '0 : cnt_q + cnt_t'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-cathode 7-segment display
// with frame-aligned double buffering and leading-zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    seg7_scan_ctrl_if.slave  bus
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef logic [IDX_W-1:0] idx_t;

    logic wrap;
    logic in_guard;
    logic frame_wrap;

    idx_t idx_q;
    idx_t idx_d;

    bcd_digit_t [NUM_DIGITS-1:0] active_bcd_q, active_bcd_d;
    bcd_digit_t [NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
    logic [NUM_DIGITS-1:0]       active_dp_q, active_dp_d;
    logic [NUM_DIGITS-1:0]       shadow_dp_q, shadow_dp_d;
    logic                        pending_q, pending_d;

    logic [NUM_DIGITS-1:0]       blank_mask;

    logic [NUM_DIGITS-1:0]       digit_en_q, digit_en_d;
    bcd_digit_t                  bcd_out_q, bcd_out_d;
    logic                        dp_out_q, dp_out_d;
    logic                        frame_tick_q, frame_tick_d;

    seg7_refresh_div #(
        .REFRESH_DIV (REFRESH_DIV),
        .GUARD       (GUARD)
    ) u_refresh_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .wrap_o     (wrap),
        .in_guard_o (in_guard)
    );

    assign frame_wrap = wrap && (idx_q == idx_t'(NUM_DIGITS - 1));

    always_comb begin
        idx_d = idx_q;
        if (wrap) begin
            idx_d = frame_wrap ? '0 : idx_q + idx_t'(1);
        end
    end

    // The active value only ever changes on a frame boundary, so a frame is never torn.
    always_comb begin
        active_bcd_d = active_bcd_q;
        active_dp_d  = active_dp_q;
        shadow_bcd_d = shadow_bcd_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        if (bus.load) begin
            shadow_bcd_d = bus.bcd_in;
            shadow_dp_d  = bus.dp_in;
            pending_d    = 1'b1;
        end
        if (frame_wrap) begin
            if (bus.load) begin
                active_bcd_d = bus.bcd_in;
                active_dp_d  = bus.dp_in;
                pending_d    = 1'b0;
            end else if (pending_q) begin
                active_bcd_d = shadow_bcd_q;
                active_dp_d  = shadow_dp_q;
                pending_d    = 1'b0;
            end
        end
    end

    // A digit is blank when it and every more significant digit are zero; digit 0 never is.
    always_comb begin
        logic zeros_above;
        zeros_above = 1'b1;
        blank_mask  = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zeros_above   = zeros_above && (active_bcd_q[i] == 4'h0);
            blank_mask[i] = bus.blank_en && zeros_above;
        end
    end

    always_comb begin
        digit_en_d   = in_guard ? '0 : NUM_DIGITS'(onehot(32'(idx_q)));
        bcd_out_d    = blank_mask[idx_q] ? BLANK_CODE : active_bcd_q[idx_q];
        dp_out_d     = active_dp_q[idx_q] && !in_guard;
        frame_tick_d = frame_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            active_bcd_q <= '0;
            active_dp_q  <= '0;
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            active_bcd_q <= active_bcd_d;
            active_dp_q  <= active_dp_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_en_q   <= '0;
            bcd_out_q    <= BLANK_CODE;
            dp_out_q     <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            digit_en_q   <= digit_en_d;
            bcd_out_q    <= bcd_out_d;
            dp_out_q     <= dp_out_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.digit_en   = digit_en_q;
    assign bus.bcd_out    = bcd_out_q;
    assign bus.dp_out     = dp_out_q;
    assign bus.pending    = pending_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 4 digits, 8-cycle slots and a 2-cycle guard.
// curK counts rising edges since the last frame start (or reset release).
module tb_seg7_scan_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   curK   = 0;
    int   enCount;

    seg7_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .GUARD       (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the directed sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkDigit(input string tag, input logic [3:0] expEn,
                              input logic [3:0] expBcd, input logic expDp);
        checkOutput({tag, ".digit_en"}, 32'(bus.digit_en), 32'(expEn));
        checkOutput({tag, ".bcd_out"},  32'(bus.bcd_out),  32'(expBcd));
        checkOutput({tag, ".dp_out"},   32'(bus.dp_out),   32'(expDp));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        curK++;
    endtask

    task automatic goToK(input int target);
        while (curK < target) step();
    endtask

    // Drives the value inputs and, when doLoad is set, holds load high for exactly one edge.
    task automatic applyStimulus(input logic doLoad, input logic [15:0] bcd,
                                 input logic [3:0] dp, input logic blank);
        bus.bcd_in   = bcd;
        bus.dp_in    = dp;
        bus.blank_en = blank;
        bus.load     = doLoad;
        step();
        bus.load     = 1'b0;
    endtask

    task automatic waitFrameTick(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (bus.frame_tick === 1'b1) seen = 1'b1;
        end
        checkOutput(tag, 32'(seen), 32'd1);
        curK = 0;
    endtask

    initial begin
        bus.load     = 1'b0;
        bus.bcd_in   = '0;
        bus.dp_in    = '0;
        bus.blank_en = 1'b0;

        // Scenario 1: reset, release, idle scan of the all-zero value
        #2 rst_n = 1'b0;
        @(negedge clk);
        checkDigit("rst", 4'b0000, 4'hF, 1'b0);
        checkOutput("rst.pending", 32'(bus.pending), 32'd0);
        checkOutput("rst.frame_tick", 32'(bus.frame_tick), 32'd0);
        rst_n = 1'b1;
        curK  = 0;
        goToK(1);  checkOutput("s1.k1.en", 32'(bus.digit_en), 32'h0);
        goToK(2);  checkOutput("s1.k2.en", 32'(bus.digit_en), 32'h0);
        goToK(3);  checkDigit("s1.k3", 4'b0001, 4'h0, 1'b0);
        goToK(12); checkDigit("s1.k12", 4'b0010, 4'h0, 1'b0);
        goToK(31); checkOutput("s1.k31.tick", 32'(bus.frame_tick), 32'd0);
        goToK(32); checkOutput("s1.k32.tick", 32'(bus.frame_tick), 32'd1);
        curK = 0;
        goToK(1);  checkOutput("s1.k1.tick", 32'(bus.frame_tick), 32'd0);
        goToK(32); checkOutput("s1.tick2", 32'(bus.frame_tick), 32'd1);
        curK = 0;

        // Scenario 2: plain load, shown from the next frame
        applyStimulus(1'b1, 16'h1234, 4'b0100, 1'b0);
        checkOutput("s2.pending.set", 32'(bus.pending), 32'd1);
        goToK(20); checkOutput("s2.pending.hold", 32'(bus.pending), 32'd1);
        waitFrameTick("s2.wait");
        checkOutput("s2.pending.clr", 32'(bus.pending), 32'd0);
        goToK(4);  checkDigit("s2.d0", 4'b0001, 4'h4, 1'b0);
        goToK(8);
        enCount = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.digit_en === 4'b0010) enCount++;
        end
        checkOutput("s2.d1.slots", 32'(enCount), 32'd6);
        goToK(12); checkDigit("s2.d1", 4'b0010, 4'h3, 1'b0);
        goToK(17); checkDigit("s2.d2.guard", 4'b0000, 4'h2, 1'b0);
        goToK(20); checkDigit("s2.d2", 4'b0100, 4'h2, 1'b1);
        goToK(24); checkOutput("s2.d2.last.dp", 32'(bus.dp_out), 32'd1);
        goToK(25); checkOutput("s2.d3.guard.en", 32'(bus.digit_en), 32'h0);
        goToK(28); checkDigit("s2.d3", 4'b1000, 4'h1, 1'b0);

        // Scenario 3: leading-zero blanking
        applyStimulus(1'b1, 16'h0050, 4'b0000, 1'b1);
        waitFrameTick("s3.wait");
        goToK(4);  checkDigit("s3.d0", 4'b0001, 4'h0, 1'b0);
        goToK(12); checkDigit("s3.d1", 4'b0010, 4'h5, 1'b0);
        goToK(20); checkDigit("s3.d2", 4'b0100, 4'hF, 1'b0);
        goToK(28); checkDigit("s3.d3", 4'b1000, 4'hF, 1'b0);
        applyStimulus(1'b1, 16'h0000, 4'b0000, 1'b1);
        waitFrameTick("s3.zero.wait");
        goToK(4);  checkDigit("s3.zero.d0", 4'b0001, 4'h0, 1'b0);
        goToK(12); checkDigit("s3.zero.d1", 4'b0010, 4'hF, 1'b0);
        goToK(28); checkDigit("s3.zero.d3", 4'b1000, 4'hF, 1'b0);

        // Scenario 4: mid-frame loads never tear the displayed frame
        applyStimulus(1'b1, 16'h1111, 4'b0000, 1'b0);
        waitFrameTick("s4.wait");
        goToK(4);  checkDigit("s4.d0", 4'b0001, 4'h1, 1'b0);
        goToK(18);
        applyStimulus(1'b1, 16'h9999, 4'b0000, 1'b0);
        goToK(20); checkDigit("s4.d2.old", 4'b0100, 4'h1, 1'b0);
        checkOutput("s4.pending", 32'(bus.pending), 32'd1);
        goToK(28); checkDigit("s4.d3.old", 4'b1000, 4'h1, 1'b0);
        goToK(29);
        applyStimulus(1'b1, 16'h8888, 4'b0000, 1'b0);
        waitFrameTick("s4.new.wait");
        goToK(4);  checkOutput("s4.new.d0", 32'(bus.bcd_out), 32'h8);
        goToK(12); checkOutput("s4.new.d1", 32'(bus.bcd_out), 32'h8);
        goToK(20); checkOutput("s4.new.d2", 32'(bus.bcd_out), 32'h8);
        goToK(28); checkOutput("s4.new.d3", 32'(bus.bcd_out), 32'h8);

        // Scenario 5: load in the exact frame_wrap cycle bypasses the shadow
        goToK(31);
        applyStimulus(1'b1, 16'h4321, 4'b0000, 1'b0);
        checkOutput("s5.tick", 32'(bus.frame_tick), 32'd1);
        checkOutput("s5.pending", 32'(bus.pending), 32'd0);
        curK = 0;
        goToK(4);  checkDigit("s5.d0", 4'b0001, 4'h1, 1'b0);
        goToK(12); checkDigit("s5.d1", 4'b0010, 4'h2, 1'b0);
        checkOutput("s5.pending.hold", 32'(bus.pending), 32'd0);

        // Scenario 6: reset pulse mid-slot discards a pending shadow value
        applyStimulus(1'b1, 16'h5678, 4'b1111, 1'b1);
        checkOutput("s6.pending.set", 32'(bus.pending), 32'd1);
        goToK(14);
        rst_n = 1'b0;
        #1;
        checkDigit("s6.async", 4'b0000, 4'hF, 1'b0);
        checkOutput("s6.async.pending", 32'(bus.pending), 32'd0);
        checkOutput("s6.async.tick", 32'(bus.frame_tick), 32'd0);
        @(negedge clk);
        step();
        checkDigit("s6.held", 4'b0000, 4'hF, 1'b0);
        rst_n = 1'b1;
        curK  = 0;
        goToK(2);  checkOutput("s6.k2.en", 32'(bus.digit_en), 32'h0);
        goToK(3);  checkDigit("s6.d0", 4'b0001, 4'h0, 1'b0);
        goToK(12); checkDigit("s6.d1", 4'b0010, 4'hF, 1'b0);
        waitFrameTick("s6.wait");
        checkOutput("s6.pending.after", 32'(bus.pending), 32'd0);
        goToK(4);  checkDigit("s6.next.d0", 4'b0001, 4'h0, 1'b0);
        goToK(20); checkDigit("s6.next.d2", 4'b0100, 4'hF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
